div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle 32-bit signed/unsigned integer divider attached to the EX stage.
- Serves DIV/DIVU; its result is written to HI/LO.
- While a divide is running, EX raises ex_stall into the pipeline stall controller, which freezes PC through EX. EX drives that ex_stall as start && !ready.
- Radix-2 restoring algorithm, one quotient bit per cycle.

Parameters:
- DATA_W, 32, operand width. result is 2*DATA_W. Iteration count equals DATA_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- signed_div  in  1  1 = signed divide (DIV), 0 = unsigned (DIVU). Sampled with start.
- opdata1  in  DATA_W  dividend. Sampled with start.
- opdata2  in  DATA_W  divisor. Sampled with start.
- start  in  1  request. EX holds it high until ready is seen, then drops it.
- annul  in  1  cancel the operation in flight (flush/exception).
- result  out  2*DATA_W  {remainder, quotient}. Upper half goes to HI, lower half to LO.
- ready  out  1  result valid.

Behaviour:
- Reset (reset=0, async): state=FREE, result=0, ready=0, iteration counter=0, internal dividend/divisor registers=0.

State FREE:
- start=1 && annul=0, divisor==0 → BYZERO.
- start=1 && annul=0, divisor!=0 → ON. Latch operands:
  - if signed_div=1, each negative operand is replaced by its two's-complement magnitude;
  - latch flags neg_q = sign1 XOR sign2 and neg_r = sign1 (signed only);
  - counter=0; partial remainder=0.
- Otherwise stay in FREE; ready=0, result=0.

State BYZERO:
- Next edge → END with result=0 and ready=1.

State ON, one iteration per cycle:
- Shift {partial remainder, dividend} left by 1.
- Trial subtract the divisor from the partial remainder.
  - If no borrow: the remainder takes the difference and quotient bit=1.
  - Else: the remainder is kept and quotient bit=0.
- counter increments.
- When counter==DATA_W at a clock edge (no further iteration):
  - if neg_q, quotient is negated; if neg_r, remainder is negated (two's complement, modulo 2^DATA_W);
  - result is written; ready=1; → END.
- annul=1 at any edge while in ON → FREE, ready=0, result=0. No partial result is exposed.

State END:
- ready=1 and result held stable.
- start=0 → FREE, ready=0, result=0.
- start still 1 → stay in END, outputs held.

Latency (start first sampled high at edge k, divisor!=0):
- Edge k enters ON.
- Edges k+1..k+32 perform the 32 iterations.
- Edge k+33 enters END with ready=1.
- ready is visible in the cycle after edge k+33, i.e. 34 cycles after start is presented.

Latency, divide-by-zero:
- ready visible after edge k+1.
- result=0.
- No exception is raised; software-defined on MIPS.

Arithmetic rules:
- Truncating division; remainder takes the sign of the dividend.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0 (wraps; no trap).
- Unsigned ops never negate.

Other rules:
- annul in FREE blocks acceptance of start that cycle.
- annul in BYZERO/END: ignored; the normal exit applies.
- Operand changes after acceptance are ignored.
- reset low mid-operation aborts immediately to the reset values.
- ready is never high outside END.

Test Plan:
1. Unsigned 100/7, start held → after 34 cycles ready=1, result=0x00000002_0000000E; drop start → next cycle ready=0, result=0.
2. Signed −7/2 (0xFFFFFFF9 / 0x00000002) → result=0xFFFFFFFF_FFFFFFFD. Signed 7/−2 → 0x00000001_FFFFFFFD. Unsigned 0xFFFFFFF9/2 → 0x00000001_7FFFFFFC.
3. Divide by zero: 5/0, signed and unsigned → ready after 2 cycles, result=0. Signed 0x80000000/0xFFFFFFFF → result=0x00000000_80000000 after 34 cycles.
4. annul pulsed 10 cycles after start → FREE next edge, ready never rises. A new start of 9/3 then completes normally: result=0x00000000_00000003.
5. Start held high through END for 3 extra cycles → ready and result remain stable the whole time. Back-to-back op accepted only after start drops for at least one cycle.
6. reset asserted low asynchronously mid-ON (between edges) → ready=0, result=0 immediately. After release, 0xFFFFFFFF/1 unsigned → result=0x00000000_FFFFFFFF.

Source files
------------

// File: rtl/div_unit_if.sv
// Divider request/response bundle between the EX stage and div_unit.
//   signed_div : 1 = DIV (signed), 0 = DIVU; sampled with start
//   opdata1    : dividend; sampled with start
//   opdata2    : divisor; sampled with start
//   start      : request, held high by EX until ready is seen
//   annul      : cancel the operation in flight (flush/exception)
//   result     : {remainder, quotient}; upper half to HI, lower half to LO
//   ready      : result valid
// master = EX stage, slave = divider.
interface div_unit_if #(
    parameter int unsigned DATA_W = 32
);
    logic                  signed_div;
    logic [DATA_W-1:0]     opdata1;
    logic [DATA_W-1:0]     opdata2;
    logic                  start;
    logic                  annul;
    logic [2*DATA_W-1:0]   result;
    logic                  ready;

    modport master (
        output signed_div,
        output opdata1,
        output opdata2,
        output start,
        output annul,
        input  result,
        input  ready
    );

    modport slave (
        input  signed_div,
        input  opdata1,
        input  opdata2,
        input  start,
        input  annul,
        output result,
        output ready
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, one quotient bit per clock.
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous active-low reset
//   bus   : div_unit_if slave (operands, start/annul in; result/ready out)
// Signed operands are divided as magnitudes; quotient/remainder signs are
// restored at the end (truncating division, remainder follows the dividend).
module div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    div_unit_if.slave  bus
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        StFree,
        StByZero,
        StOn,
        StEnd
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]     rem_q, rem_d;     // partial remainder
    logic [DATA_W-1:0]     dvd_q, dvd_d;     // dividend, shifts out as quotient shifts in
    logic [DATA_W-1:0]     dvs_q, dvs_d;     // divisor magnitude
    logic                  neg_q_q, neg_q_d;
    logic                  neg_r_q, neg_r_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;

    logic                  sign1, sign2;
    logic [DATA_W-1:0]     mag1, mag2;
    logic [DATA_W:0]       trial;            // extra bit catches the bit shifted out of rem
    logic                  borrow;
    logic [DATA_W-1:0]     quot_fin, rem_fin;

    assign sign1 = bus.signed_div & bus.opdata1[DATA_W-1];
    assign sign2 = bus.signed_div & bus.opdata2[DATA_W-1];
    assign mag1  = sign1 ? -bus.opdata1 : bus.opdata1;
    assign mag2  = sign2 ? -bus.opdata2 : bus.opdata2;

    // rem < divisor is invariant, so the shifted remainder minus divisor fits in
    // DATA_W bits when it does not borrow; bit DATA_W is the borrow.
    assign trial  = {rem_q, dvd_q[DATA_W-1]} - {1'b0, dvs_q};
    assign borrow = trial[DATA_W];

    assign quot_fin = neg_q_q ? -dvd_q : dvd_q;
    assign rem_fin  = neg_r_q ? -rem_q : rem_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StFree;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        result_d = result_q;
        ready_d  = ready_q;

        unique case (state_q)
            StFree: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (bus.start && !bus.annul) begin
                    if (bus.opdata2 == '0) begin
                        state_d = StByZero;
                    end else begin
                        state_d = StOn;
                        dvd_d   = mag1;
                        dvs_d   = mag2;
                        neg_q_d = sign1 ^ sign2;
                        neg_r_d = sign1;
                        cnt_d   = '0;
                        rem_d   = '0;
                    end
                end
            end

            StByZero: begin
                state_d  = StEnd;
                result_d = '0;
                ready_d  = 1'b1;
            end

            StOn: begin
                if (bus.annul) begin
                    state_d  = StFree;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (cnt_q == CntW'(DATA_W)) begin
                    state_d  = StEnd;
                    result_d = {rem_fin, quot_fin};
                    ready_d  = 1'b1;
                end else begin
                    rem_d = borrow ? {rem_q[DATA_W-2:0], dvd_q[DATA_W-1]}
                                   : trial[DATA_W-1:0];
                    dvd_d = {dvd_q[DATA_W-2:0], ~borrow};
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StEnd: begin
                if (!bus.start) begin
                    state_d  = StFree;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end

            default: begin
                state_d  = StFree;
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    assign bus.result = result_q;
    assign bus.ready  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed scenarios plus random operands,
// checked against an arithmetic reference model.
module tb_div_unit;

    logic clk;
    logic reset;
    int   n_vectors;
    int   n_miscompares;

    div_unit_if #(.DATA_W(32)) bus ();

    div_unit #(.DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Truncating division, remainder takes the dividend's sign, x/0 gives 0.
    function automatic logic [63:0] model(input bit sd, input logic [31:0] a,
                                          input logic [31:0] b);
        int sa;
        int sb;
        int q;
        int r;
        if (b == 32'd0) return 64'd0;
        if (!sd) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {r, q};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vectors++;
        assert (obs === exp)
        else begin
            n_miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge. Raises start (leaves it high), waits for
    // ready, checks latency and result. Operands are scrambled after acceptance.
    task automatic do_op(input string tag, input bit sd, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat);
        int lat;
        bus.signed_div = sd;
        bus.opdata1    = a;
        bus.opdata2    = b;
        bus.start      = 1'b1;
        lat = 0;
        while (!bus.ready && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                bus.opdata1    = $urandom;
                bus.opdata2    = $urandom;
                bus.signed_div = ~sd;
            end
        end
        check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        check({tag, ".res"}, bus.result, model(sd, a, b));
    endtask

    task automatic drop_start(input string tag);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, ".drop_rdy"}, 64'(bus.ready), 64'd0);
        check({tag, ".drop_res"}, bus.result, 64'd0);
    endtask

    initial begin
        logic [63:0] held;
        bit          saw;
        bit          sd;
        logic [31:0] a;
        logic [31:0] b;

        n_vectors      = 0;
        n_miscompares  = 0;
        reset          = 1'b0;
        bus.start      = 1'b0;
        bus.annul      = 1'b0;
        bus.signed_div = 1'b0;
        bus.opdata1    = '0;
        bus.opdata2    = '0;

        #12;
        check("reset.rdy", 64'(bus.ready), 64'd0);
        check("reset.res", bus.result, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 1: unsigned 100/7
        do_op("u100_7", 1'b0, 32'd100, 32'd7, 34);
        check("u100_7.const", bus.result, 64'h0000_0002_0000_000E);
        drop_start("u100_7");

        // 2: sign handling
        do_op("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 34);
        check("s-7_2.const", bus.result, 64'hFFFF_FFFF_FFFF_FFFD);
        drop_start("s-7_2");
        do_op("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 34);
        check("s7_-2.const", bus.result, 64'h0000_0001_FFFF_FFFD);
        drop_start("s7_-2");
        do_op("uFFF9_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 34);
        check("uFFF9_2.const", bus.result, 64'h0000_0001_7FFF_FFFC);
        drop_start("uFFF9_2");

        // 3: divide by zero and the signed overflow case
        do_op("s5_0", 1'b1, 32'd5, 32'd0, 2);
        drop_start("s5_0");
        do_op("u5_0", 1'b0, 32'd5, 32'd0, 2);
        drop_start("u5_0");
        do_op("smin_-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34);
        check("smin_-1.const", bus.result, 64'h0000_0000_8000_0000);
        drop_start("smin_-1");

        // 4: annul mid-operation, then a clean 9/3
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'd1000;
        bus.opdata2    = 32'd3;
        bus.start      = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.annul = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.annul = 1'b0;
        check("annul.res", bus.result, 64'd0);
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.ready) saw = 1'b1;
        end
        check("annul.no_rdy", 64'(saw), 64'd0);
        do_op("u9_3", 1'b0, 32'd9, 32'd3, 34);
        check("u9_3.const", bus.result, 64'h0000_0000_0000_0003);
        drop_start("u9_3");

        // annul in FREE blocks acceptance for that edge only
        bus.opdata1 = 32'd50;
        bus.opdata2 = 32'd6;
        bus.start   = 1'b1;
        bus.annul   = 1'b1;
        @(posedge clk);
        #1;
        bus.annul = 1'b0;
        do_op("annul_free", 1'b0, 32'd50, 32'd6, 34);
        drop_start("annul_free");

        // 5: start held through END, then back-to-back after a one-cycle drop
        do_op("hold", 1'b1, 32'hFFFF_FF00, 32'd10, 34);
        held = model(1'b1, 32'hFFFF_FF00, 32'd10);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("hold.rdy", 64'(bus.ready), 64'd1);
            check("hold.res", bus.result, held);
        end
        drop_start("hold");
        do_op("b2b", 1'b0, 32'd12345, 32'd77, 34);
        drop_start("b2b");

        // 6: asynchronous reset in END and mid-ON
        do_op("rst_end", 1'b0, 32'd100, 32'd7, 34);
        #3;
        reset = 1'b0;
        #1;
        check("rst_end.rdy", 64'(bus.ready), 64'd0);
        check("rst_end.res", bus.result, 64'd0);
        #2;
        reset = 1'b1;
        bus.opdata1 = 32'd99;
        bus.opdata2 = 32'd5;
        bus.start   = 1'b1;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("rst_on.rdy", 64'(bus.ready), 64'd0);
        check("rst_on.res", bus.result, 64'd0);
        bus.start = 1'b0;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_op("uFFFF_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 34);
        check("uFFFF_1.const", bus.result, 64'h0000_0000_FFFF_FFFF);
        drop_start("uFFFF_1");

        // Random operands against the model
        for (int i = 0; i < 24; i++) begin
            sd = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                3:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
            do_op("rand", sd, a, b, (b == 32'd0) ? 2 : 34);
            drop_start("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
